pio_bus_sched: RTL and testbench
================================

Name: pio_bus_sched

Overview:
- Scheduler that owns the pio host action bus (mindex/din/index/action/dout) and shares it among three traffic classes:
  - one configuration requester;
  - four per-machine TX streams feeding the TX FIFOs via PUSH;
  - RX draining of the four RX FIFOs via PULL into one tagged output stream.
- Sits directly between the host/SoC fabric and pio. It is the only driver of pio's action port.
- Sequences each pio operation with the hold and settle cycles pio needs. Never pushes into a full FIFO and never pulls from an empty one.

Parameters:
- NUM_SM, 4, number of state machines (fixed at 4 by pio; other values unsupported).
- DW, 32, data width of the FIFO and din paths.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous active-high reset
- cfg_valid  in  1  config request
- cfg_action  in  4  pio action code
- cfg_mindex  in  2  target machine
- cfg_index  in  5  instruction index
- cfg_din  in  32  config data
- cfg_ready  out  1  config accepted (1-cycle pulse)
- cfg_err  out  1  sticky: config request carried PUSH or PULL
- tx_valid  in  4  per-machine TX data valid
- tx_data  in  128  per-machine TX data; machine j uses bits [32j+31:32j]
- tx_ready  out  4  per-machine accept (1-cycle pulse)
- rx_valid  out  1  RX word available
- rx_data  out  32  RX word
- rx_sm  out  2  source machine of the RX word
- rx_ready  in  1  consumer accepts the RX word
- busy  out  1  FSM not in IDLE
- pio_mindex  out  2  to pio mindex
- pio_index  out  5  to pio index
- pio_din  out  32  to pio din
- pio_action  out  4  to pio action
- pio_dout  in  32  from pio dout
- pio_tx_full  in  4  from pio tx_full
- pio_rx_empty  in  4  from pio rx_empty

Behaviour:
- Reset (synchronous, active-high, also applied mid-operation):
  - state returns to IDLE and the round-robin pointer to 0;
  - all outputs go to 0: pio_action=NONE(0), pio_din, pio_index, pio_mindex, tx_ready, cfg_ready, rx_valid, rx_data, rx_sm, cfg_err, busy;
  - any in-flight operation is abandoned; pio is reset by the same signal.
- FSM states: IDLE -> ISSUE -> HOLD -> SETTLE -> IDLE. Each operation occupies 4 cycles; there is no back-to-back issue.
- IDLE, arbitration (registered at the IDLE edge):
  - cfg_valid has absolute priority.
  - Otherwise an 8-slot round-robin applies. Slot j (0-3) is TX for machine j, eligible if tx_valid[j] & !pio_tx_full[j]. Slot 4+j is RX for machine j, eligible if !pio_rx_empty[j] & !rx_valid.
  - Search starts at the pointer. After a grant the pointer moves to granted slot+1, mod 8. A cfg grant does not move the pointer.
- Grant in IDLE:
  - the matching ready (cfg_ready or tx_ready[j]) is asserted in that same IDLE cycle;
  - action, mindex, index and din are latched into output registers.
- ISSUE (1 cycle):
  - pio_action carries the granted op: PUSH(4) for TX, PULL(3) for RX, or cfg_action for cfg.
  - For TX and RX, pio_index=0. For TX, pio_din=tx data. For RX, pio_din=0.
  - cfg_action of PUSH or PULL is driven as NONE and sets cfg_err.
- HOLD (1 cycle):
  - pio_action=NONE while pio_din, pio_mindex and pio_index are held; the FIFO samples din here.
  - For an RX op, pio_dout is valid in this cycle. It is captured at the end of HOLD into rx_data, with rx_sm=mindex and rx_valid=1.
- SETTLE (1 cycle):
  - pio_action=NONE; outputs hold.
  - This lets tx_full/rx_empty reflect the op before the next arbitration.
- RX output buffer (one entry):
  - rx_valid holds until rx_valid & rx_ready; it is cleared on that edge.
  - While rx_valid=1, RX slots are ineligible.
- Simultaneous events: cfg_valid together with TX/RX eligibility gives cfg first. Requests that arrive while not in IDLE wait, with no loss.
- Boundary handling:
  - tx_full[j]=1 blocks slot j only, not other machines.
  - Only flag values seen in IDLE are used.
  - Changing tx_valid without a handshake is allowed; only handshaked data reaches pio.

Decomposition:
- Shared package pio_pkg holds:
  - action codes NONE=0, INSTR=1, PEND=2, PULL=3, PUSH=4, GRPS=5, EN=6, DIV=7, SIDES=8, IMM=9, SHIFT=10;
  - the FSM state encoding.
- One sub-module, rr_arb8: 8-request round-robin picker with a pointer input, producing grant index and grant valid. It is purely combinational; the pointer register stays in pio_bus_sched.

Test Plan:
- After reset, cfg_valid with action=INSTR, index=3, din=0x0000E081 -> cfg_ready in cycle 1; pio_action=1, index=3, din=0xE081 for exactly 1 cycle; din held 1 more cycle; busy low after 4 cycles.
- tx_valid=4'b0101 with data 0x11111111 (sm0) and 0x33333333 (sm2) -> PUSH to sm0, then PUSH to sm2, 4 cycles apart, each with a tx_ready pulse.
- pio_tx_full[1]=1 with tx_valid[1]=1 -> no PUSH to sm1 and tx_ready[1]=0 until full drops; sm3 traffic still proceeds.
- pio_rx_empty[2]=0, dout=0xCAFEF00D -> PULL to mindex 2; rx_valid=1, rx_data=0xCAFEF00D, rx_sm=2. With rx_ready=0 held, no further PULL occurs.
- cfg_action=PUSH -> pio_action stays NONE and cfg_err=1 until reset. Reset asserted during HOLD -> next cycle all outputs 0 and state IDLE.

Source files
------------

// File: rtl/pio_pkg.sv
// Shared definitions for the pio host-bus scheduler: pio action codes,
// scheduler state encoding and the bus geometry.
package pio_pkg;

   localparam int PIO_NUM_SM = 4;
   localparam int PIO_DW     = 32;
   localparam int PIO_SLOTS  = 2 * PIO_NUM_SM;
   localparam int PIO_SLOT_W = $clog2(PIO_SLOTS);

   typedef enum logic [3:0] {
      ACT_NONE  = 4'd0,
      ACT_INSTR = 4'd1,
      ACT_PEND  = 4'd2,
      ACT_PULL  = 4'd3,
      ACT_PUSH  = 4'd4,
      ACT_GRPS  = 4'd5,
      ACT_EN    = 4'd6,
      ACT_DIV   = 4'd7,
      ACT_SIDES = 4'd8,
      ACT_IMM   = 4'd9,
      ACT_SHIFT = 4'd10
   } pio_action_t;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_ISSUE  = 2'd1,
      ST_HOLD   = 2'd2,
      ST_SETTLE = 2'd3
   } sched_state_t;

   // FIFO actions are reserved for the TX/RX streams; config may not use them
   function automatic logic is_fifo_action(input logic [3:0] act);
      return (act == ACT_PUSH) || (act == ACT_PULL);
   endfunction

endpackage

// File: rtl/rr_arb8.sv
// Eight-request round-robin picker. The search starts at ptr and wraps;
// the first asserted request wins. Purely combinational -- the caller owns
// the pointer register.
module rr_arb8
   import pio_pkg::*;
(
   input  logic [PIO_SLOTS-1:0]  req,
   input  logic [PIO_SLOT_W-1:0] ptr,
   output logic [PIO_SLOT_W-1:0] gnt_idx,
   output logic                  gnt_valid
);

   logic [PIO_SLOT_W-1:0] probe;

   // Walk from the farthest offset back to ptr so the nearest request wins
   always_comb begin
      gnt_valid = 1'b0;
      gnt_idx   = ptr;
      probe     = ptr;
      for (int i = PIO_SLOTS - 1; i >= 0; i--) begin
         probe = ptr + PIO_SLOT_W'(i);
         if (req[probe]) begin
            gnt_valid = 1'b1;
            gnt_idx   = probe;
         end
      end
   end

endmodule

// File: rtl/pio_bus_sched.sv
// Sole driver of the pio action bus. Shares it between one config requester,
// four TX streams (PUSH into the TX FIFOs) and RX draining (PULL from the RX
// FIFOs into a single tagged output word). Every operation runs
// IDLE -> ISSUE -> HOLD -> SETTLE so pio sees a one-cycle action pulse, a
// held data phase and a settle cycle before the FIFO flags are trusted again.
module pio_bus_sched
   import pio_pkg::*;
#(
   parameter int NUM_SM = PIO_NUM_SM,
   parameter int DW     = PIO_DW
)
(
   input  logic                 clk,
   input  logic                 reset,

   input  logic                 cfg_valid,
   input  logic [3:0]           cfg_action,
   input  logic [1:0]           cfg_mindex,
   input  logic [4:0]           cfg_index,
   input  logic [DW-1:0]        cfg_din,
   output logic                 cfg_ready,
   output logic                 cfg_err,

   input  logic [NUM_SM-1:0]    tx_valid,
   input  logic [NUM_SM*DW-1:0] tx_data,
   output logic [NUM_SM-1:0]    tx_ready,

   output logic                 rx_valid,
   output logic [DW-1:0]        rx_data,
   output logic [1:0]           rx_sm,
   input  logic                 rx_ready,

   output logic                 busy,

   output logic [1:0]           pio_mindex,
   output logic [4:0]           pio_index,
   output logic [DW-1:0]        pio_din,
   output logic [3:0]           pio_action,
   input  logic [DW-1:0]        pio_dout,
   input  logic [NUM_SM-1:0]    pio_tx_full,
   input  logic [NUM_SM-1:0]    pio_rx_empty
);

   sched_state_t              state;
   logic [PIO_SLOT_W-1:0]     rr_ptr;
   logic                      op_is_rx;

   logic [PIO_SLOTS-1:0]      req;
   logic [PIO_SLOT_W-1:0]     gnt_idx;
   logic                      gnt_valid;
   logic                      in_idle;
   logic                      cfg_grant;
   logic                      rr_grant;
   logic [NUM_SM-1:0][DW-1:0] tx_words;

   assign tx_words = tx_data;

   // Slot j pushes machine j's TX word; slot NUM_SM+j pulls machine j's RX FIFO
   always_comb begin
      req = '0;
      for (int j = 0; j < NUM_SM; j++) begin
         req[j]          = tx_valid[j] & ~pio_tx_full[j];
         req[NUM_SM + j] = ~pio_rx_empty[j] & ~rx_valid;
      end
   end

   rr_arb8 u_arb (
      .req       (req),
      .ptr       (rr_ptr),
      .gnt_idx   (gnt_idx),
      .gnt_valid (gnt_valid)
   );

   assign in_idle   = (state == ST_IDLE) && !reset;
   assign cfg_grant = in_idle && cfg_valid;
   assign rr_grant  = in_idle && !cfg_valid && gnt_valid;
   assign cfg_ready = cfg_grant;
   assign busy      = (state != ST_IDLE);

   // The accepting ready pulses in the IDLE cycle so the word handshaked is
   // exactly the word latched onto the pio bus at the same edge
   always_comb begin
      tx_ready = '0;
      if (rr_grant && !gnt_idx[PIO_SLOT_W-1]) begin
         tx_ready[gnt_idx[1:0]] = 1'b1;
      end
   end

   // Operation sequencer: grants in IDLE, one-cycle action pulse in ISSUE,
   // RX capture at the end of HOLD, then a settle cycle before re-arbitrating
   always_ff @(posedge clk) begin
      if (reset) begin
         state      <= ST_IDLE;
         rr_ptr     <= '0;
         op_is_rx   <= 1'b0;
         pio_action <= ACT_NONE;
         pio_din    <= '0;
         pio_index  <= '0;
         pio_mindex <= '0;
         rx_valid   <= 1'b0;
         rx_data    <= '0;
         rx_sm      <= '0;
         cfg_err    <= 1'b0;
      end else begin
         if (rx_valid && rx_ready) begin
            rx_valid <= 1'b0;
         end

         case (state)
            ST_IDLE: begin
               if (cfg_valid) begin
                  state      <= ST_ISSUE;
                  op_is_rx   <= 1'b0;
                  pio_mindex <= cfg_mindex;
                  pio_index  <= cfg_index;
                  pio_din    <= cfg_din;
                  if (is_fifo_action(cfg_action)) begin
                     pio_action <= ACT_NONE;
                     cfg_err    <= 1'b1;
                  end else begin
                     pio_action <= cfg_action;
                  end
               end else if (gnt_valid) begin
                  state      <= ST_ISSUE;
                  rr_ptr     <= gnt_idx + PIO_SLOT_W'(1);
                  pio_mindex <= gnt_idx[1:0];
                  pio_index  <= '0;
                  if (gnt_idx[PIO_SLOT_W-1]) begin
                     op_is_rx   <= 1'b1;
                     pio_action <= ACT_PULL;
                     pio_din    <= '0;
                  end else begin
                     op_is_rx   <= 1'b0;
                     pio_action <= ACT_PUSH;
                     pio_din    <= tx_words[gnt_idx[1:0]];
                  end
               end
            end

            ST_ISSUE: begin
               pio_action <= ACT_NONE;
               state      <= ST_HOLD;
            end

            ST_HOLD: begin
               if (op_is_rx) begin
                  rx_valid <= 1'b1;
                  rx_data  <= pio_dout;
                  rx_sm    <= pio_mindex;
               end
               state <= ST_SETTLE;
            end

            default: begin
               state <= ST_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_pio_bus_sched.sv
// Bench for pio_bus_sched: a table of single operations started from reset,
// hand-built multi-cycle sequences, and a randomized run against a
// transaction-level reference of the arbitration and bus-timing rules.
module tb_pio_bus_sched;
   import pio_pkg::*;

   logic         clk = 1'b0;
   logic         reset;
   logic         cfg_valid;
   logic [3:0]   cfg_action;
   logic [1:0]   cfg_mindex;
   logic [4:0]   cfg_index;
   logic [31:0]  cfg_din;
   logic         cfg_ready;
   logic         cfg_err;
   logic [3:0]   tx_valid;
   logic [127:0] tx_data;
   logic [3:0]   tx_ready;
   logic         rx_valid;
   logic [31:0]  rx_data;
   logic [1:0]   rx_sm;
   logic         rx_ready;
   logic         busy;
   logic [1:0]   pio_mindex;
   logic [4:0]   pio_index;
   logic [31:0]  pio_din;
   logic [3:0]   pio_action;
   logic [31:0]  pio_dout;
   logic [3:0]   pio_tx_full;
   logic [3:0]   pio_rx_empty;

   pio_bus_sched dut (
      .clk          (clk),
      .reset        (reset),
      .cfg_valid    (cfg_valid),
      .cfg_action   (cfg_action),
      .cfg_mindex   (cfg_mindex),
      .cfg_index    (cfg_index),
      .cfg_din      (cfg_din),
      .cfg_ready    (cfg_ready),
      .cfg_err      (cfg_err),
      .tx_valid     (tx_valid),
      .tx_data      (tx_data),
      .tx_ready     (tx_ready),
      .rx_valid     (rx_valid),
      .rx_data      (rx_data),
      .rx_sm        (rx_sm),
      .rx_ready     (rx_ready),
      .busy         (busy),
      .pio_mindex   (pio_mindex),
      .pio_index    (pio_index),
      .pio_din      (pio_din),
      .pio_action   (pio_action),
      .pio_dout     (pio_dout),
      .pio_tx_full  (pio_tx_full),
      .pio_rx_empty (pio_rx_empty)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        cv;
      logic [3:0]  ca;
      logic [1:0]  cm;
      logic [4:0]  ci;
      logic [31:0] cd;
      logic [3:0]  tv;
      logic [31:0] tw;
      logic [3:0]  tf;
      logic [3:0]  re;
      logic [31:0] dout;
      logic        ecr;
      logic [3:0]  etr;
      logic [3:0]  eact;
      logic [1:0]  em;
      logic [4:0]  ei;
      logic [31:0] ed;
      logic        erv;
      logic [31:0] erd;
      logic [1:0]  ers;
      logic        eerr;
   } vec_t;

   vec_t vecs [10];

   int compared   = 0;
   int mismatched = 0;

   // Reference model state for the randomized run
   int          m_stage;
   int          m_ptr;
   int          gslot;
   int          s;
   bit          elig;
   bit          grant_cfg;
   logic [3:0]  exp_tx;
   logic [3:0]  m_action;
   logic [1:0]  m_mindex;
   logic [4:0]  m_index;
   logic [31:0] m_din;
   bit          m_op_rx;
   logic        m_rx_valid;
   logic [31:0] m_rx_data;
   logic [1:0]  m_rx_sm;
   logic        m_err;
   int          hits;

   task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
      compared++;
      if (actual !== expected) begin
         mismatched++;
         $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
      end
   endtask

   task automatic stepCycle();
      @(posedge clk);
      #1;
   endtask

   task automatic sampleWait();
      @(negedge clk);
   endtask

   task automatic clearInputs();
      cfg_valid    = 1'b0;
      cfg_action   = 4'd0;
      cfg_mindex   = 2'd0;
      cfg_index    = 5'd0;
      cfg_din      = 32'd0;
      tx_valid     = 4'd0;
      tx_data      = 128'd0;
      rx_ready     = 1'b0;
      pio_dout     = 32'd0;
      pio_tx_full  = 4'd0;
      pio_rx_empty = 4'hF;
   endtask

   task automatic doReset();
      clearInputs();
      reset = 1'b1;
      stepCycle();
      stepCycle();
      reset = 1'b0;
   endtask

   task automatic applyStimulus(input vec_t v, input int n);
      string tag;
      tag = $sformatf("vec%0d", n);
      doReset();
      cfg_valid    = v.cv;
      cfg_action   = v.ca;
      cfg_mindex   = v.cm;
      cfg_index    = v.ci;
      cfg_din      = v.cd;
      tx_valid     = v.tv;
      for (int j = 0; j < 4; j++) tx_data[32*j +: 32] = v.tw * 32'(j + 1);
      pio_tx_full  = v.tf;
      pio_rx_empty = v.re;
      pio_dout     = v.dout;
      sampleWait();
      checkOutput({tag, "_ready"}, 64'({cfg_ready, tx_ready}), 64'({v.ecr, v.etr}));
      stepCycle();
      cfg_valid    = 1'b0;
      tx_valid     = 4'd0;
      pio_tx_full  = 4'd0;
      pio_rx_empty = 4'hF;
      sampleWait();
      checkOutput({tag, "_issue"}, 64'({busy, pio_action, pio_mindex, pio_index}), 64'({1'b1, v.eact, v.em, v.ei}));
      checkOutput({tag, "_din"}, 64'(pio_din), 64'(v.ed));
      stepCycle();
      sampleWait();
      checkOutput({tag, "_hold"}, 64'({pio_action, pio_din}), 64'({4'd0, v.ed}));
      stepCycle();
      sampleWait();
      checkOutput({tag, "_rx"}, 64'({cfg_err, rx_valid, rx_sm, rx_data}), 64'({v.eerr, v.erv, v.ers, v.erd}));
      stepCycle();
      sampleWait();
      checkOutput({tag, "_idle"}, 64'(busy), 64'(0));
   endtask

   // Reference: one cycle of expected outputs, then advance across the edge
   task automatic modelCycle();
      grant_cfg = 1'b0;
      exp_tx    = 4'd0;
      gslot     = -1;
      if (m_stage == 0) begin
         if (cfg_valid) grant_cfg = 1'b1;
         else begin
            for (int k = 0; k < 8; k++) begin
               s = (m_ptr + k) % 8;
               if (s < 4) elig = tx_valid[s] && !pio_tx_full[s];
               else       elig = !pio_rx_empty[s-4] && !m_rx_valid;
               if (gslot < 0 && elig) gslot = s;
            end
            if (gslot >= 0 && gslot < 4) exp_tx[gslot] = 1'b1;
         end
      end
      checkOutput("rnd_ctl",
         64'({cfg_ready, tx_ready, busy, pio_action, pio_mindex, pio_index, rx_valid, rx_sm, cfg_err}),
         64'({grant_cfg, exp_tx, m_stage != 0, m_action, m_mindex, m_index, m_rx_valid, m_rx_sm, m_err}));
      checkOutput("rnd_data", {pio_din, rx_data}, {m_din, m_rx_data});

      if (m_rx_valid && rx_ready) m_rx_valid = 1'b0;
      case (m_stage)
         0: begin
            if (grant_cfg) begin
               m_action = (cfg_action == 4'd3 || cfg_action == 4'd4) ? 4'd0 : cfg_action;
               if (cfg_action == 4'd3 || cfg_action == 4'd4) m_err = 1'b1;
               m_mindex = cfg_mindex;
               m_index  = cfg_index;
               m_din    = cfg_din;
               m_op_rx  = 1'b0;
               m_stage  = 1;
            end else if (gslot >= 0) begin
               m_index = 5'd0;
               m_ptr   = (gslot + 1) % 8;
               m_stage = 1;
               if (gslot < 4) begin
                  m_action = 4'd4;
                  m_mindex = 2'(gslot);
                  m_din    = tx_data[32*gslot +: 32];
                  m_op_rx  = 1'b0;
               end else begin
                  m_action = 4'd3;
                  m_mindex = 2'(gslot - 4);
                  m_din    = 32'd0;
                  m_op_rx  = 1'b1;
               end
            end
         end
         1: begin
            m_action = 4'd0;
            m_stage  = 2;
         end
         2: begin
            if (m_op_rx) begin
               m_rx_valid = 1'b1;
               m_rx_data  = pio_dout;
               m_rx_sm    = m_mindex;
            end
            m_stage = 3;
         end
         default: m_stage = 0;
      endcase
   endtask

   initial begin
      vecs[0] = '{1'b1, 4'd1,  2'd0, 5'd3, 32'h0000E081, 4'b0000, 32'h0,        4'b0000, 4'b1111, 32'h0,
                  1'b1, 4'b0000, 4'd1,  2'd0, 5'd3, 32'h0000E081, 1'b0, 32'h0,        2'd0, 1'b0};
      vecs[1] = '{1'b0, 4'd0,  2'd0, 5'd0, 32'h0,        4'b0001, 32'h11111111, 4'b0000, 4'b1111, 32'h0,
                  1'b0, 4'b0001, 4'd4,  2'd0, 5'd0, 32'h11111111, 1'b0, 32'h0,        2'd0, 1'b0};
      vecs[2] = '{1'b0, 4'd0,  2'd0, 5'd0, 32'h0,        4'b0100, 32'h11111111, 4'b0000, 4'b1111, 32'h0,
                  1'b0, 4'b0100, 4'd4,  2'd2, 5'd0, 32'h33333333, 1'b0, 32'h0,        2'd0, 1'b0};
      vecs[3] = '{1'b0, 4'd0,  2'd0, 5'd0, 32'h0,        4'b1010, 32'h11111111, 4'b0010, 4'b1111, 32'h0,
                  1'b0, 4'b1000, 4'd4,  2'd3, 5'd0, 32'h44444444, 1'b0, 32'h0,        2'd0, 1'b0};
      vecs[4] = '{1'b0, 4'd0,  2'd0, 5'd0, 32'h0,        4'b0000, 32'h0,        4'b0000, 4'b1011, 32'hCAFEF00D,
                  1'b0, 4'b0000, 4'd3,  2'd2, 5'd0, 32'h0,        1'b1, 32'hCAFEF00D, 2'd2, 1'b0};
      vecs[5] = '{1'b1, 4'd10, 2'd1, 5'd7, 32'h00005A5A, 4'b1111, 32'h11111111, 4'b0000, 4'b0000, 32'h0,
                  1'b1, 4'b0000, 4'd10, 2'd1, 5'd7, 32'h00005A5A, 1'b0, 32'h0,        2'd0, 1'b0};
      vecs[6] = '{1'b1, 4'd4,  2'd3, 5'd2, 32'h0000FFFF, 4'b0000, 32'h0,        4'b0000, 4'b1111, 32'h0,
                  1'b1, 4'b0000, 4'd0,  2'd3, 5'd2, 32'h0000FFFF, 1'b0, 32'h0,        2'd0, 1'b1};
      vecs[7] = '{1'b0, 4'd0,  2'd0, 5'd0, 32'h0,        4'b1000, 32'h11111111, 4'b0000, 4'b1110, 32'h0,
                  1'b0, 4'b1000, 4'd4,  2'd3, 5'd0, 32'h44444444, 1'b0, 32'h0,        2'd0, 1'b0};
      vecs[8] = '{1'b1, 4'd3,  2'd0, 5'd0, 32'h00000001, 4'b0000, 32'h0,        4'b0000, 4'b1111, 32'h0,
                  1'b1, 4'b0000, 4'd0,  2'd0, 5'd0, 32'h00000001, 1'b0, 32'h0,        2'd0, 1'b1};
      vecs[9] = '{1'b0, 4'd0,  2'd0, 5'd0, 32'h0,        4'b0000, 32'h0,        4'b0000, 4'b0111, 32'h00000001,
                  1'b0, 4'b0000, 4'd3,  2'd3, 5'd0, 32'h0,        1'b1, 32'h00000001, 2'd3, 1'b0};

      // Reset state
      doReset();
      sampleWait();
      checkOutput("reset_ctl", 64'({cfg_ready, cfg_err, tx_ready, rx_valid, rx_sm, busy, pio_action, pio_mindex, pio_index}), 64'(0));
      checkOutput("reset_data", {pio_din, rx_data}, 64'(0));

      $display("[TB] table vectors");
      for (int n = 0; n < 10; n++) applyStimulus(vecs[n], n);

      $display("[TB] two TX streams share the bus");
      doReset();
      tx_valid = 4'b0101;
      tx_data[31:0]  = 32'h11111111;
      tx_data[95:64] = 32'h33333333;
      sampleWait();
      checkOutput("seqA_ready0", 64'(tx_ready), 64'(4'b0001));
      stepCycle();
      tx_valid = 4'b0100;
      sampleWait();
      checkOutput("seqA_push0", 64'({pio_action, pio_mindex, pio_din}), 64'({4'd4, 2'd0, 32'h11111111}));
      checkOutput("seqA_noready", 64'(tx_ready), 64'(0));
      stepCycle(); stepCycle(); stepCycle();
      sampleWait();
      checkOutput("seqA_ready2", 64'(tx_ready), 64'(4'b0100));
      stepCycle();
      tx_valid = 4'b0000;
      sampleWait();
      checkOutput("seqA_push2", 64'({pio_action, pio_mindex, pio_din}), 64'({4'd4, 2'd2, 32'h33333333}));

      $display("[TB] full TX FIFO blocks only its machine");
      doReset();
      tx_valid    = 4'b1010;
      pio_tx_full = 4'b0010;
      tx_data[63:32]  = 32'hA1A1A1A1;
      tx_data[127:96] = 32'hA3A3A3A3;
      sampleWait();
      checkOutput("seqD_sm3", 64'(tx_ready), 64'(4'b1000));
      stepCycle();
      tx_valid = 4'b0010;
      hits = 0;
      for (int c = 0; c < 10; c++) begin
         sampleWait();
         if (tx_ready[1] || (pio_action == 4'd4 && pio_mindex == 2'd1)) hits++;
         stepCycle();
      end
      checkOutput("seqD_blocked", 64'(hits), 64'(0));
      pio_tx_full = 4'b0000;
      sampleWait();
      checkOutput("seqD_release", 64'(tx_ready), 64'(4'b0010));
      stepCycle();
      tx_valid = 4'b0000;
      sampleWait();
      checkOutput("seqD_push1", 64'({pio_action, pio_mindex, pio_din}), 64'({4'd4, 2'd1, 32'hA1A1A1A1}));

      $display("[TB] RX buffer backpressure");
      doReset();
      pio_rx_empty = 4'b1011;
      pio_dout     = 32'hCAFEF00D;
      hits = 0;
      for (int c = 0; c < 16; c++) begin
         sampleWait();
         if (pio_action == 4'd3) hits++;
         stepCycle();
      end
      checkOutput("seqB_pulls", 64'(hits), 64'(1));
      checkOutput("seqB_word", 64'({rx_valid, rx_sm, rx_data}), 64'({1'b1, 2'd2, 32'hCAFEF00D}));
      rx_ready = 1'b1;
      stepCycle();
      rx_ready     = 1'b0;
      pio_rx_empty = 4'hF;
      sampleWait();
      checkOutput("seqB_drained", 64'({rx_valid, pio_action}), 64'(0));

      $display("[TB] cfg error and reset during HOLD");
      doReset();
      cfg_valid  = 1'b1;
      cfg_action = 4'd4;
      cfg_mindex = 2'd1;
      cfg_index  = 5'd9;
      cfg_din    = 32'h00001234;
      sampleWait();
      checkOutput("seqC_ready", 64'(cfg_ready), 64'(1));
      stepCycle();
      cfg_valid = 1'b0;
      sampleWait();
      checkOutput("seqC_issue", 64'({pio_action, cfg_err, busy}), 64'({4'd0, 1'b1, 1'b1}));
      stepCycle();
      sampleWait();
      checkOutput("seqC_hold", 64'({cfg_err, pio_mindex, pio_din}), 64'({1'b1, 2'd1, 32'h00001234}));
      reset = 1'b1;
      stepCycle();
      reset = 1'b0;
      sampleWait();
      checkOutput("seqC_rst_ctl", 64'({cfg_ready, cfg_err, tx_ready, rx_valid, rx_sm, busy, pio_action, pio_mindex, pio_index}), 64'(0));
      checkOutput("seqC_rst_data", {pio_din, rx_data}, 64'(0));
      stepCycle();
      cfg_valid  = 1'b1;
      cfg_action = 4'd1;
      sampleWait();
      checkOutput("seqC_idle_after", 64'(cfg_ready), 64'(1));
      stepCycle();
      cfg_valid = 1'b0;
      stepCycle(); stepCycle(); stepCycle();

      $display("[TB] randomized run against reference");
      doReset();
      m_stage = 0; m_ptr = 0; m_action = 4'd0; m_mindex = 2'd0; m_index = 5'd0;
      m_din = 32'd0; m_op_rx = 1'b0; m_rx_valid = 1'b0; m_rx_data = 32'd0;
      m_rx_sm = 2'd0; m_err = 1'b0;
      for (int c = 0; c < 3000; c++) begin
         cfg_valid    = ($urandom_range(0, 15) == 0);
         cfg_action   = 4'($urandom_range(0, 10));
         cfg_mindex   = 2'($urandom);
         cfg_index    = 5'($urandom);
         cfg_din      = $urandom;
         tx_valid     = 4'($urandom);
         tx_data      = {$urandom, $urandom, $urandom, $urandom};
         pio_tx_full  = 4'($urandom) & 4'($urandom);
         pio_rx_empty = 4'($urandom) | 4'($urandom);
         rx_ready     = ($urandom_range(0, 3) == 0);
         pio_dout     = $urandom;
         sampleWait();
         modelCycle();
         stepCycle();
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
